mem_port_arbiter: RTL

Sequences a single-ported unified memory shared by the pipeline's instruction-fetch port and data-memory port. It holds one outstanding memory transaction at a time. It arbitrates round-robin when both ports request in the same cycle. It returns read data and a one-cycle ack to the winning port, and it aborts hung transactions through a timeout counter. The block sits between the F/M pipeline stages and the external memory; the pipeline control derives stalls from req & ~ack.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data pipeline ports, the arbiter and the
// single-ported unified memory.
interface mem_port_arbiter_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BEW = 4
) ();
  logic           if_req;
  logic [AW-1:0]  if_addr;
  logic [DW-1:0]  if_rdata;
  logic           if_ack;

  logic           dm_req;
  logic           dm_wr;
  logic [BEW-1:0] dm_be;
  logic [AW-1:0]  dm_addr;
  logic [DW-1:0]  dm_wdata;
  logic [DW-1:0]  dm_rdata;
  logic           dm_ack;

  logic           mem_req;
  logic           mem_wr;
  logic [BEW-1:0] mem_be;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ack;

  logic           err;
  logic           busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_be, dm_addr, dm_wdata,
           mem_rdata, mem_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack,
           mem_req, mem_wr, mem_be, mem_addr, mem_wdata, err, busy
  );

  // Pipeline ports plus memory, as seen from the environment
  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_be, dm_addr, dm_wdata,
           mem_rdata, mem_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
           mem_req, mem_wr, mem_be, mem_addr, mem_wdata, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch and
// data ports; one transaction in flight, timeout abort for hung accesses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction; pick an eligible port and launch mem_req
// ST_BUSY_I | fetch read in flight, waiting for mem_ack or timeout
// ST_BUSY_D | data read/write in flight, waiting for mem_ack or timeout
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int BEW     = 4,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rr_dm_q, rr_dm_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_wr_q, mem_wr_d;
  logic [BEW-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]  if_rdata_q, if_rdata_d;
  logic [DW-1:0]  dm_rdata_q, dm_rdata_d;
  logic           if_ack_q, if_ack_d;
  logic           dm_ack_q, dm_ack_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic           if_elig;
  logic           dm_elig;
  logic           timeout_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_dm_d     = rr_dm_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;

    // A port whose ack is showing this cycle is still holding its old request.
    if_elig     = bus.if_req & ~if_ack_q;
    dm_elig     = bus.dm_req & ~dm_ack_q;
    // cnt_q counts completed wait cycles, so LAST marks the TIMEOUT-th BUSY cycle
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (dm_elig && (!if_elig || rr_dm_q)) begin
          state_d     = ST_BUSY_D;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_wr_d    = bus.dm_wr;
          mem_be_d    = bus.dm_be;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
        end else if (if_elig) begin
          state_d     = ST_BUSY_I;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_be_d    = '1;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        if (bus.mem_ack || timeout_hit) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          rr_dm_d   = (state_q == ST_BUSY_I);
          err_d     = ~bus.mem_ack;
          if (state_q == ST_BUSY_I) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            dm_ack_d = 1'b1;
            if (!bus.mem_ack)
              dm_rdata_d = '0;
            else if (!mem_wr_q)
              dm_rdata_d = bus.mem_rdata;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rr_dm_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_dm_q     <= rr_dm_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule
